win_stats: RTL and testbench

- Downstream consumer of the 8-bit free-running counter stage.
- Collects fixed-size blocks of 2^LOG2_WIN incoming samples and computes the sum, truncated average, maximum and minimum of each block.
- Presents each result on a valid/ready output port and holds it until accepted.
- Serves as the checker/statistics stage that consumes counter output in the interview-problem set.

---
 rtl/win_stats.sv | 61 ++++++
 tb/tb_win_stats.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/win_stats.sv
// win_stats: per-block sum, truncated average, max and min over 2^LOG2_WIN samples,
// presented on a valid/ready port and held until accepted.
module win_stats #(
  parameter int DW       = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW+LOG2_WIN-1:0] out_sum,
  output logic [DW-1:0]          out_avg,
  output logic [DW-1:0]          out_max,
  output logic [DW-1:0]          out_min,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int SW = DW + LOG2_WIN;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, next_state;
  logic [LOG2_WIN-1:0] cnt;
  logic [SW-1:0] acc_sum, sum_n;
  logic [DW-1:0] acc_max, acc_min, max_n, min_n;
  logic take, last;
  assign take    = in_valid && in_ready;
  assign last    = take && (cnt == '1);
  assign sum_n   = acc_sum + SW'(in_data);
  assign max_n   = in_data > acc_max ? in_data : acc_max;
  assign min_n   = in_data < acc_min ? in_data : acc_min;
  assign out_avg = out_sum[SW-1:LOG2_WIN];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else state <= next_state;
  always_comb next_state = state == ACCUM ? (last ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
  always_comb begin
    in_ready  = state == ACCUM && !rst;
    out_valid = state == HOLD;
  end
  // The final sample is folded in on the way to the output registers; accumulators restart.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      acc_sum <= '0;
      acc_max <= '0;
      acc_min <= '1;
      out_sum <= '0;
      out_max <= '0;
      out_min <= '0;
    end else if (take) begin
      cnt     <= cnt + 1'b1;
      acc_sum <= last ? '0 : sum_n;
      acc_max <= last ? '0 : max_n;
      acc_min <= last ? '1 : min_n;
      if (last) begin
        out_sum <= sum_n;
        out_max <= max_n;
        out_min <= min_n;
      end
    end
endmodule

// File: tb/tb_win_stats.sv
// tb_win_stats: directed and random stimulus against a queue-based block statistics model.
module tb_win_stats;
  localparam int DW = 8;
  localparam int L  = 3;
  localparam int WIN = 1 << L;
  typedef struct {
    int sum;
    int avg;
    int mx;
    int mn;
  } res_t;
  logic clk = 0, rst = 1;
  logic [DW-1:0] in_data = 0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [DW+L-1:0] out_sum;
  logic [DW-1:0] out_avg, out_max, out_min;
  int vectors = 0, miscompares = 0;
  int blk[$];
  res_t exq[$];
  bit exp_hold = 0;

  win_stats #(.DW(DW), .LOG2_WIN(L)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_avg(out_avg), .out_max(out_max), .out_min(out_min),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic res_t stats(input int s[$]);
    res_t r;
    r.sum = 0;
    r.mx = s[0];
    r.mn = s[0];
    foreach (s[i]) begin
      r.sum += s[i];
      if (s[i] > r.mx) r.mx = s[i];
      if (s[i] < r.mn) r.mn = s[i];
    end
    r.avg = r.sum / WIN;
    return r;
  endfunction

  // Monitor: checks handshake signals and held results against the model every cycle.
  always @(negedge clk) begin
    if (rst) begin
      blk.delete();
      exq.delete();
      exp_hold = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
    end else begin
      chk("in_ready", int'(in_ready), int'(!exp_hold));
      chk("out_valid", int'(out_valid), int'(exp_hold));
      if (exp_hold) begin
        if (exq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty: got out_valid=%0d, expected a queued result", out_valid);
        end else begin
          chk("out_sum", int'(out_sum), exq[0].sum);
          chk("out_avg", int'(out_avg), exq[0].avg);
          chk("out_max", int'(out_max), exq[0].mx);
          chk("out_min", int'(out_min), exq[0].mn);
          if (out_ready) void'(exq.pop_front());
        end
        if (out_ready) exp_hold = 0;
      end else if (in_valid) begin
        blk.push_back(int'(in_data));
        if (blk.size() == WIN) begin
          exq.push_back(stats(blk));
          blk.delete();
          exp_hold = 1;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid = v;
    in_data = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    logic a;
    in_valid = 1;
    in_data = d;
    do begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 50);
    if (!a) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    in_valid = 0;
  endtask

  task automatic pulse_rst();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) send(8'(i));
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) send(8'd255);
    cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) send(8'(252 + i));
    cyc(0, 0, 1);
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(8'(i));
    for (int i = 0; i < 5; i++) cyc(1, 8, 0);
    out_ready = 1;
    for (int i = 8; i < 16; i++) send(8'(i));
    cyc(0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i * 10));
      cyc(0, 0, 1);
    end
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) send(8'd100);
    pulse_rst();
    for (int i = 0; i < 8; i++) send(8'd1);
    cyc(0, 0, 1);
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(8'(i + 40));
    pulse_rst();
    cyc(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_rst();
      else cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
